// File: rtl/operand_fetch_if.sv
// operand_fetch_if: request and operand handshake bundle between the issue
// stage, operand_fetch and the ALU.
//   master: issue/ALU side (drives requests, consumes operands)
//   slave : operand_fetch side
interface operand_fetch_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
);
    localparam int IW = $clog2(NREGS);

    logic             req_valid;
    logic             req_ready;
    logic [IW-1:0]    srcA;
    logic [IW-1:0]    srcB;
    logic             useImm;
    logic [WIDTH-1:0] imm;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;

    modport master (
        output req_valid, srcA, srcB, useImm, imm, op_ready,
        input  req_ready, op_valid, opA, opB
    );

    modport slave (
        input  req_valid, srcA, srcB, useImm, imm, op_ready,
        output req_ready, op_valid, opA, opB
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: reads two source operands from the flat regfile outputs and
// queues them in a 2-entry FIFO toward the ALU.
// Optional feature macro: OPERAND_BYPASS_EN
//   defined   -> a same-cycle regfile write is forwarded into the operand
//   undefined -> no forwarding; a request that hits a pending write stalls
//                one cycle until the write has landed in the regfile

// Per-operand read port: selects one register and reports a write hit on it.
module operand_fetch_sel #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int IW    = $clog2(NREGS)
) (
    input  logic [NREGS*WIDTH-1:0] regs,
    input  logic [NREGS-1:0]       wbEnable,
    input  logic [WIDTH-1:0]       wbBus,
    input  logic [IW-1:0]          idx,
    output logic [WIDTH-1:0]       val,
    output logic                   hit
);
    // r0 sits in the most significant slice, so an ascending view indexes directly
    logic [0:NREGS-1][WIDTH-1:0] rf;
    assign rf  = regs;
    assign hit = wbEnable[idx];

`ifdef OPERAND_BYPASS_EN
    // forward the value being written this cycle; regs still holds the old one
    always_comb val = hit ? wbBus : rf[idx];
`else
    logic unused_bus;
    assign unused_bus = ^wbBus;
    // no forwarding: the top-level stall guarantees regs is current at push
    always_comb val = rf[idx];
`endif
endmodule

module operand_fetch #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREGS*WIDTH-1:0] regs,
    input  logic [NREGS-1:0]       wbEnable,
    input  logic [WIDTH-1:0]       wbBus,
    operand_fetch_if.slave         io
);
    localparam int IW = $clog2(NREGS);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t                  state_q, state_d;
    entry_t                  head_q, tail_q, new_ent;
    logic [1:0][IW-1:0]      idx;
    logic [1:0][WIDTH-1:0]   rd;
    logic [1:0]              hit;
    logic                    stall;
    logic                    push, pop;
    logic                    head_ld_new, head_ld_tail, tail_ld;

    assign idx = {io.srcB, io.srcA};

    // lane 0 = operand A, lane 1 = operand B
    for (genvar i = 0; i < 2; i++) begin : g_sel
        operand_fetch_sel #(.WIDTH(WIDTH), .NREGS(NREGS), .IW(IW)) u_sel (
            .regs     (regs),
            .wbEnable (wbEnable),
            .wbBus    (wbBus),
            .idx      (idx[i]),
            .val      (rd[i]),
            .hit      (hit[i])
        );
    end

`ifdef OPERAND_BYPASS_EN
    logic unused_hit;
    assign unused_hit = ^hit;
    assign stall = 1'b0;
`else
    // an immediate B operand never reads regs, so its write hit is irrelevant
    assign stall = (hit[0] || (!io.useImm && hit[1])) && io.req_valid;
`endif

    assign new_ent.a    = rd[0];
    assign new_ent.b    = io.useImm ? io.imm : rd[1];

    assign io.req_ready = (state_q != TWO) && !stall;
    assign io.op_valid  = (state_q != EMPTY);
    assign io.opA       = head_q.a;
    assign io.opB       = head_q.b;

    assign push = io.req_valid && io.req_ready;
    assign pop  = io.op_valid && io.op_ready;

    // occupancy next-state and entry load selects
    always_comb begin
        state_d      = state_q;
        head_ld_new  = 1'b0;
        head_ld_tail = 1'b0;
        tail_ld      = 1'b0;
        case (state_q)
            EMPTY: if (push) begin
                state_d     = ONE;
                head_ld_new = 1'b1;
            end
            ONE: begin
                if (push && pop) begin
                    head_ld_new = 1'b1;
                end else if (push) begin
                    state_d = TWO;
                    tail_ld = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (pop) begin
                state_d      = ONE;
                head_ld_tail = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    // occupancy register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // entry storage; head holds its value when the FIFO drains
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (head_ld_new)       head_q <= new_ent;
            else if (head_ld_tail) head_q <= tail_q;
            if (tail_ld)           tail_q <= new_ent;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks for operand_fetch. Inputs change and
// outputs are sampled on the falling edge; the DUT updates on the rising edge.
module tb_operand_fetch;
    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] regs;
    logic [15:0]  wbEnable;
    logic [15:0]  wbBus;
    logic [15:0]  rf [16];
    int           pass_cnt  = 0;
    int           total_cnt = 0;

    operand_fetch_if #(.WIDTH(16), .NREGS(16)) io ();

    operand_fetch #(.WIDTH(16), .NREGS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .regs     (regs),
        .wbEnable (wbEnable),
        .wbBus    (wbBus),
        .io       (io)
    );

    always #5 clk = ~clk;

    always_comb begin
        regs = '0;
        for (int n = 0; n < 16; n++) regs[255-16*n -: 16] = rf[n];
    end

    task automatic idle_req();
        io.req_valid = 1'b0;
        io.srcA = '0; io.srcB = '0; io.useImm = 1'b0; io.imm = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        total_cnt++; if (io.op_valid !== 1'b0) $display("FAIL reset_op_valid: got %b want 0", io.op_valid); else pass_cnt++;
        total_cnt++; if (io.opA !== 16'h0) $display("FAIL reset_opA: got %h want 0000", io.opA); else pass_cnt++;
        total_cnt++; if (io.opB !== 16'h0) $display("FAIL reset_opB: got %h want 0000", io.opB); else pass_cnt++;
        @(negedge clk); reset = 1'b1; #1;
        total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", io.req_ready); else pass_cnt++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        io.req_valid = 1'b1; io.srcA = 4'd3; io.srcB = 4'd7; io.useImm = 1'b0; io.op_ready = 1'b1;
        #1;
        total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL basic_req_ready: got %b want 1", io.req_ready); else pass_cnt++;
        @(negedge clk); idle_req();
        total_cnt++; if (io.op_valid !== 1'b1) $display("FAIL basic_op_valid: got %b want 1", io.op_valid); else pass_cnt++;
        total_cnt++; if (io.opA !== 16'h1234) $display("FAIL basic_opA: got %h want 1234", io.opA); else pass_cnt++;
        total_cnt++; if (io.opB !== 16'hBEEF) $display("FAIL basic_opB: got %h want beef", io.opB); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (io.op_valid !== 1'b0) $display("FAIL drain_op_valid: got %b want 0", io.op_valid); else pass_cnt++;
        total_cnt++; if (io.opA !== 16'h1234) $display("FAIL hold_opA: got %h want 1234", io.opA); else pass_cnt++;
    endtask

    task automatic test_imm();
        @(negedge clk);
        io.req_valid = 1'b1; io.srcA = 4'd0; io.srcB = 4'd7; io.useImm = 1'b1; io.imm = 16'hFFFF;
        @(negedge clk); idle_req();
        total_cnt++; if (io.opA !== 16'h0005) $display("FAIL imm_opA: got %h want 0005", io.opA); else pass_cnt++;
        total_cnt++; if (io.opB !== 16'hFFFF) $display("FAIL imm_opB: got %h want ffff", io.opB); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        io.op_ready = 1'b0;
        io.req_valid = 1'b1; io.srcA = 4'd1; io.srcB = 4'd9;
        #1;
        total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL bp_ready0: got %b want 1", io.req_ready); else pass_cnt++;
        @(negedge clk);
        io.srcA = 4'd2; io.srcB = 4'd10;
        #1;
        total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", io.req_ready); else pass_cnt++;
        total_cnt++; if (io.opA !== rf[1]) $display("FAIL bp_head1: got %h want %h", io.opA, rf[1]); else pass_cnt++;
        @(negedge clk);
        io.srcA = 4'd3; io.srcB = 4'd11;
        #1;
        total_cnt++; if (io.req_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", io.req_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (io.req_ready !== 1'b0) $display("FAIL bp_full_hold: got %b want 0", io.req_ready); else pass_cnt++;
        total_cnt++; if (io.opA !== rf[1]) $display("FAIL bp_head_hold: got %h want %h", io.opA, rf[1]); else pass_cnt++;
        io.op_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (io.opA !== rf[2]) $display("FAIL bp_out2_A: got %h want %h", io.opA, rf[2]); else pass_cnt++;
        total_cnt++; if (io.opB !== rf[10]) $display("FAIL bp_out2_B: got %h want %h", io.opB, rf[10]); else pass_cnt++;
        total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL bp_reopen: got %b want 1", io.req_ready); else pass_cnt++;
        @(negedge clk); idle_req();
        total_cnt++; if (io.op_valid !== 1'b1) $display("FAIL bp_out3_valid: got %b want 1", io.op_valid); else pass_cnt++;
        total_cnt++; if (io.opA !== rf[3]) $display("FAIL bp_out3_A: got %h want %h", io.opA, rf[3]); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (io.op_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", io.op_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        io.op_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total_cnt++; if (io.op_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, io.op_valid); else pass_cnt++;
                total_cnt++; if (io.opA !== rf[i-1]) $display("FAIL b2b_opA[%0d]: got %h want %h", i, io.opA, rf[i-1]); else pass_cnt++;
                total_cnt++; if (io.opB !== rf[15-(i-1)]) $display("FAIL b2b_opB[%0d]: got %h want %h", i, io.opB, rf[15-(i-1)]); else pass_cnt++;
            end
            io.req_valid = 1'b1; io.srcA = 4'(i); io.srcB = 4'(15 - i); io.useImm = 1'b0;
            #1;
            total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, io.req_ready); else pass_cnt++;
        end
        @(negedge clk); idle_req();
        total_cnt++; if (io.opA !== rf[7]) $display("FAIL b2b_last: got %h want %h", io.opA, rf[7]); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_hazard();
        logic exp_ready;
`ifdef OPERAND_BYPASS_EN
        exp_ready = 1'b1;
`else
        exp_ready = 1'b0;
`endif
        // immediate B hides a write to srcB: never stalls
        @(negedge clk);
        wbEnable = 16'h1 << 9; wbBus = 16'h5A5A;
        io.req_valid = 1'b1; io.srcA = 4'd0; io.srcB = 4'd9; io.useImm = 1'b1; io.imm = 16'h0042;
        #1;
        total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL haz_imm_ready: got %b want 1", io.req_ready); else pass_cnt++;
        @(posedge clk); #1;
        rf[9] = 16'h5A5A; wbEnable = '0; idle_req();
        @(negedge clk);
        total_cnt++; if (io.opB !== 16'h0042) $display("FAIL haz_imm_opB: got %h want 0042", io.opB); else pass_cnt++;
        @(negedge clk);
        // write to srcA in the push cycle
        wbEnable = 16'h1 << 5; wbBus = 16'hA5A5;
        io.req_valid = 1'b1; io.srcA = 4'd5; io.srcB = 4'd7; io.useImm = 1'b0;
        #1;
        total_cnt++; if (io.req_ready !== exp_ready) $display("FAIL haz_ready: got %b want %b", io.req_ready, exp_ready); else pass_cnt++;
        @(posedge clk); #1;
        rf[5] = 16'hA5A5; wbEnable = '0;
        if (exp_ready) idle_req();
        @(negedge clk);
        if (!exp_ready) begin
            total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL haz_retry_ready: got %b want 1", io.req_ready); else pass_cnt++;
            @(negedge clk); idle_req();
        end
        total_cnt++; if (io.op_valid !== 1'b1) $display("FAIL haz_valid: got %b want 1", io.op_valid); else pass_cnt++;
        total_cnt++; if (io.opA !== 16'hA5A5) $display("FAIL haz_opA: got %h want a5a5", io.opA); else pass_cnt++;
        total_cnt++; if (io.opB !== 16'hBEEF) $display("FAIL haz_opB: got %h want beef", io.opB); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        io.op_ready = 1'b0;
        io.req_valid = 1'b1; io.srcA = 4'd1; io.srcB = 4'd2;
        @(negedge clk);
        io.srcA = 4'd2; io.srcB = 4'd3;
        @(negedge clk); idle_req();
        total_cnt++; if (io.req_ready !== 1'b0) $display("FAIL mr_full: got %b want 0", io.req_ready); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (io.op_valid !== 1'b0) $display("FAIL mr_op_valid: got %b want 0", io.op_valid); else pass_cnt++;
        total_cnt++; if (io.opA !== 16'h0) $display("FAIL mr_opA: got %h want 0000", io.opA); else pass_cnt++;
        total_cnt++; if (io.opB !== 16'h0) $display("FAIL mr_opB: got %h want 0000", io.opB); else pass_cnt++;
        #2 reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (io.req_ready !== 1'b1) $display("FAIL mr_req_ready: got %b want 1", io.req_ready); else pass_cnt++;
        total_cnt++; if (io.op_valid !== 1'b0) $display("FAIL mr_stay_empty: got %b want 0", io.op_valid); else pass_cnt++;
    endtask

    initial begin
        for (int n = 0; n < 16; n++) rf[n] = 16'(16'h0100 * n + 16'h0011);
        rf[0] = 16'h0005; rf[3] = 16'h1234; rf[5] = 16'h0001; rf[7] = 16'hBEEF;
        wbEnable = '0; wbBus = '0;
        idle_req();
        io.op_ready = 1'b0;
        test_reset();
        test_basic();
        test_imm();
        test_backpressure();
        test_back_to_back();
        test_hazard();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
